// File: rtl/ahb_pkg.sv
// AHB-Lite shared encodings and the SRAM responder FSM state type.
// Latency: declarations only, no logic.
// Backpressure: not applicable; imported by every ahb_slave_sram file.
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DATA,
      ST_ERR1,
      ST_ERR2
   } ahb_state_t;

endpackage

// File: rtl/ahb_slave_sram_if.sv
// AHB-Lite slave-side bus bundle for one decoder select line.
// Latency: wires only.
// Backpressure: hready/hreadyout carry the bus stall in both directions.
interface ahb_slave_sram_if;
   import ahb_pkg::*;

   logic        hsel;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [31:0] hwdata;
   logic        hready;
   logic [31:0] hrdata;
   logic        hreadyout;
   logic        hresp;

   modport master (
      output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
      input  hrdata, hreadyout, hresp
   );

   modport slave (
      input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
      output hrdata, hreadyout, hresp
   );

endinterface

// File: rtl/ahb_byte_lane_dec.sv
// Byte-lane write strobe and alignment check from transfer size and addr[1:0].
// Latency: purely combinational.
// Backpressure: none; used on the address phase before the transfer is latched.
module ahb_byte_lane_dec
   import ahb_pkg::*;
(
   input  logic [2:0] i_size,
   input  logic [1:0] i_addr_lo,
   output logic [3:0] o_strb,
   output logic       o_misalign
);

   // Little-endian lane select; a halfword ignores addr[0] and a word ignores
   // addr[1:0], so misaligned or oversized transfers collapse onto aligned lanes.
   always_comb begin
      o_strb     = 4'b1111;
      o_misalign = 1'b0;
      case (i_size)
         HSIZE_BYTE: begin
            o_strb = 4'b0001 << i_addr_lo;
         end
         HSIZE_HALF: begin
            o_strb     = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            o_misalign = i_addr_lo[0];
         end
         HSIZE_WORD: begin
            o_misalign = (i_addr_lo != 2'b00);
         end
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/ahb_slave_sram.sv
// AHB-Lite word SRAM responder with programmable wait states; AHB_SLV_ERR_EN enables ERROR responses.
// Latency: OKAY data phase takes 1+WAIT_STATES cycles, ERROR data phase exactly 2.
// Backpressure: hreadyout low during wait/ERR1 cycles; new address phases accepted only with hready high.
module ahb_slave_sram
   import ahb_pkg::*;
#(
   parameter int ADDR_W      = 10,
   parameter int WAIT_STATES = 0,
   parameter int MEM_WORDS   = 256
)(
   input logic             hclk,
   input logic             hresetn,
   ahb_slave_sram_if.slave bus
);

   localparam int          MEM_AW    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam logic [2:0]  WS        = 3'(WAIT_STATES);
   localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);

   logic [31:0]       r_mem [MEM_WORDS];

   ahb_state_t        r_state;
   ahb_state_t        w_next;
   logic [2:0]        r_cnt;
   logic [2:0]        w_cnt_nxt;

   logic [MEM_AW-1:0] r_idx;
   logic              r_write;
   logic [3:0]        r_strb;

   logic [ADDR_W-3:0] w_word_raw;
   logic [MEM_AW-1:0] w_idx;
   logic [3:0]        w_strb;
   logic              w_misalign;
   logic              w_slot;
   logic              w_accept;
   logic              w_wr_en;
   logic              w_unused;
`ifdef AHB_SLV_ERR_EN
   logic              w_illegal;
`endif

   ahb_byte_lane_dec u_lane_dec (
      .i_size     (bus.hsize),
      .i_addr_lo  (bus.haddr[1:0]),
      .o_strb     (w_strb),
      .o_misalign (w_misalign)
   );

   assign w_word_raw = bus.haddr[ADDR_W-1:2];

`ifdef AHB_SLV_ERR_EN
   // Range check uses the full address so aliases above the local window are rejected.
   assign w_idx     = MEM_AW'(w_word_raw);
   assign w_illegal = (bus.haddr >= MEM_BYTES) | w_misalign | (bus.hsize > HSIZE_WORD);
   assign w_unused  = bus.htrans[0];
`else
   // Without error responses, out-of-range words wrap onto the implemented memory.
   assign w_idx     = MEM_AW'(32'(w_word_raw) % 32'(MEM_WORDS));
   assign w_unused  = ^{bus.htrans[0], w_misalign, bus.haddr[31:ADDR_W]};
`endif

   // A new address phase can only be taken while no stalled data phase is pending.
   assign w_slot   = (r_state != ST_WAIT) && (r_state != ST_ERR1);
   assign w_accept = bus.hsel & bus.hready & bus.htrans[1] & w_slot;
   assign w_wr_en  = (r_state == ST_DATA) & r_write;

   // Capture address-phase attributes of each accepted transfer.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         r_idx   <= '0;
         r_write <= 1'b0;
         r_strb  <= '0;
      end else if (w_accept) begin
         r_idx   <= w_idx;
         r_write <= bus.hwrite;
         r_strb  <= w_strb;
      end
   end

   // FSM state and wait counter registers.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next state: completing states fall through to the accept transition so
   // back-to-back transfers run without an idle bubble.
   always_comb begin
      w_next    = r_state;
      w_cnt_nxt = r_cnt;
      case (r_state)
         ST_WAIT: begin
            if (r_cnt >= WS) begin
               w_next    = ST_DATA;
               w_cnt_nxt = '0;
            end else begin
               w_cnt_nxt = r_cnt + 3'd1;
            end
         end
`ifdef AHB_SLV_ERR_EN
         ST_ERR1: begin
            w_next = ST_ERR2;
         end
`endif
         default: begin
            w_next    = ST_IDLE;
            w_cnt_nxt = '0;
            if (w_accept) begin
`ifdef AHB_SLV_ERR_EN
               if (w_illegal) begin
                  w_next = ST_ERR1;
               end else
`endif
               if (WAIT_STATES > 0) begin
                  w_next    = ST_WAIT;
                  w_cnt_nxt = 3'd1;
               end else begin
                  w_next = ST_DATA;
               end
            end
         end
      endcase
   end

   // Response outputs decoded from state; read data is only driven in DATA.
   always_comb begin
      bus.hreadyout = 1'b1;
      bus.hresp     = HRESP_OKAY;
      bus.hrdata    = '0;
      case (r_state)
         ST_WAIT: begin
            bus.hreadyout = 1'b0;
         end
         ST_DATA: begin
            if (!r_write) begin
               bus.hrdata = r_mem[r_idx];
            end
         end
`ifdef AHB_SLV_ERR_EN
         ST_ERR1: begin
            bus.hreadyout = 1'b0;
            bus.hresp     = HRESP_ERROR;
         end
         ST_ERR2: begin
            bus.hresp = HRESP_ERROR;
         end
`endif
         default: begin
         end
      endcase
   end

   // Commit write data on the edge that ends the DATA cycle; memory keeps its
   // contents across reset, and reset forces IDLE so an abandoned write never lands.
   always_ff @(posedge hclk) begin
      if (w_wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (r_strb[i]) begin
               r_mem[r_idx][8*i +: 8] <= bus.hwdata[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_ahb_slave_sram.sv
// Directed bench for ahb_slave_sram: three instances (0, 2 and 3 wait states) on one shared bus.
// Latency: expectations are fixed per cycle; outputs are sampled on the falling edge.
// Backpressure: hready is the hreadyout of the currently addressed instance.
module tb_ahb_slave_sram;
   import ahb_pkg::*;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;

   logic [1:0]  t_dut    = 2'd0;
   logic        t_hsel   = 1'b0;
   logic [31:0] t_haddr  = 32'h0;
   logic [1:0]  t_htrans = HTRANS_IDLE;
   logic        t_hwrite = 1'b0;
   logic [2:0]  t_hsize  = HSIZE_WORD;
   logic [31:0] t_hwdata = 32'h0;

   logic        m_ready;
   logic        m_resp;
   logic [31:0] m_rdata;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   ahb_slave_sram_if if0();
   ahb_slave_sram_if if1();
   ahb_slave_sram_if if2();

   assign if0.hsel   = t_hsel && (t_dut == 2'd0);
   assign if1.hsel   = t_hsel && (t_dut == 2'd1);
   assign if2.hsel   = t_hsel && (t_dut == 2'd2);
   assign if0.haddr  = t_haddr;
   assign if1.haddr  = t_haddr;
   assign if2.haddr  = t_haddr;
   assign if0.htrans = t_htrans;
   assign if1.htrans = t_htrans;
   assign if2.htrans = t_htrans;
   assign if0.hwrite = t_hwrite;
   assign if1.hwrite = t_hwrite;
   assign if2.hwrite = t_hwrite;
   assign if0.hsize  = t_hsize;
   assign if1.hsize  = t_hsize;
   assign if2.hsize  = t_hsize;
   assign if0.hwdata = t_hwdata;
   assign if1.hwdata = t_hwdata;
   assign if2.hwdata = t_hwdata;
   assign if0.hready = m_ready;
   assign if1.hready = m_ready;
   assign if2.hready = m_ready;

   always_comb begin
      m_ready = if0.hreadyout;
      m_resp  = if0.hresp;
      m_rdata = if0.hrdata;
      case (t_dut)
         2'd1: begin
            m_ready = if1.hreadyout;
            m_resp  = if1.hresp;
            m_rdata = if1.hrdata;
         end
         2'd2: begin
            m_ready = if2.hreadyout;
            m_resp  = if2.hresp;
            m_rdata = if2.hrdata;
         end
         default: begin
         end
      endcase
   end

   ahb_slave_sram #(.ADDR_W(10), .WAIT_STATES(0), .MEM_WORDS(256)) u_ws0 (
      .hclk(clk), .hresetn(rst_n), .bus(if0));
   ahb_slave_sram #(.ADDR_W(10), .WAIT_STATES(2), .MEM_WORDS(256)) u_ws2 (
      .hclk(clk), .hresetn(rst_n), .bus(if1));
   ahb_slave_sram #(.ADDR_W(10), .WAIT_STATES(3), .MEM_WORDS(256)) u_ws3 (
      .hclk(clk), .hresetn(rst_n), .bus(if2));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic neg();
      @(negedge clk);
   endtask

   task automatic put(input logic sel, input logic [1:0] tr, input logic wr,
                      input logic [2:0] sz, input logic [31:0] a);
      t_hsel   = sel;
      t_htrans = tr;
      t_hwrite = wr;
      t_hsize  = sz;
      t_haddr  = a;
   endtask

   task automatic idle();
      put(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic chk_rsp(input string tag, input logic rdy, input logic rsp);
      chk({tag, ".hreadyout"}, 32'(m_ready), 32'(rdy));
      chk({tag, ".hresp"},     32'(m_resp),  32'(rsp));
   endtask

   initial begin
      // Reset state
      #1 rst_n = 1'b0;
      #2;
      chk_rsp("reset", 1'b1, 1'b0);
      chk("reset.hrdata", m_rdata, 32'h0);
      #9 rst_n = 1'b1;
      tick();

      // Word write then back-to-back read, no wait states
      put(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h04);
      tick();
      t_hwdata = 32'hDEADBEEF;
      put(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h04);
      neg();
      chk_rsp("wr04_data", 1'b1, 1'b0);
      chk("wr04_data.hrdata", m_rdata, 32'h0);
      tick();
      idle();
      neg();
      chk("rd04", m_rdata, 32'hDEADBEEF);
      chk_rsp("rd04", 1'b1, 1'b0);

      // Byte and halfword lanes on word 0x08, data replicated on all lanes
      put(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h08);
      tick();
      t_hwdata = 32'h0;
      put(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'h0B);
      tick();
      t_hwdata = 32'hAAAAAAAA;
      put(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h08);
      tick();
      idle();
      neg();
      chk("byte_0B", m_rdata, 32'hAA000000);

      put(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_HALF, 32'h08);
      tick();
      t_hwdata = 32'h12341234;
      put(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h08);
      tick();
      idle();
      neg();
      chk("half_08", m_rdata, 32'hAA001234);

      put(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'h09);
      tick();
      t_hwdata = 32'h55555555;
      put(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h08);
      tick();
      idle();
      neg();
      chk("byte_09", m_rdata, 32'hAA005534);

      put(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_HALF, 32'h0A);
      tick();
      t_hwdata = 32'hBEEFBEEF;
      put(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h08);
      tick();
      idle();
      neg();
      chk("half_0A", m_rdata, 32'hBEEF5534);

      // IDLE with hsel=1, then NONSEQ with hsel=0: no transfer, no write
      put(1'b1, HTRANS_IDLE, 1'b1, HSIZE_WORD, 32'h04);
      tick();
      t_hwdata = 32'hFFFFFFFF;
      idle();
      neg();
      chk_rsp("idle_sel", 1'b1, 1'b0);
      put(1'b0, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h04);
      tick();
      idle();
      neg();
      chk_rsp("unsel", 1'b1, 1'b0);
      tick();
      put(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h04);
      tick();
      idle();
      neg();
      chk("rd04_after_idle", m_rdata, 32'hDEADBEEF);

      // Seed word 0, then out-of-range read and misaligned word write
      put(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h00);
      tick();
      t_hwdata = 32'h11223344;
      idle();
      tick();

      put(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h400);
      tick();
      idle();
`ifdef AHB_SLV_ERR_EN
      neg();
      chk_rsp("oor_err1", 1'b0, 1'b1);
      tick();
      neg();
      chk_rsp("oor_err2", 1'b1, 1'b1);
      tick();
      neg();
      chk_rsp("oor_after", 1'b1, 1'b0);
`else
      neg();
      chk_rsp("oor_wrap", 1'b1, 1'b0);
      chk("oor_wrap.hrdata", m_rdata, 32'h11223344);
      tick();
`endif

      put(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h02);
      tick();
      t_hwdata = 32'hCAFEF00D;
      idle();
`ifdef AHB_SLV_ERR_EN
      neg();
      chk_rsp("misal_err1", 1'b0, 1'b1);
      tick();
      neg();
      chk_rsp("misal_err2", 1'b1, 1'b1);
      tick();
`else
      neg();
      chk_rsp("misal_ok", 1'b1, 1'b0);
      tick();
`endif
      put(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h00);
      tick();
      idle();
      neg();
`ifdef AHB_SLV_ERR_EN
      chk("misal_mem", m_rdata, 32'h11223344);
`else
      chk("misal_mem", m_rdata, 32'hCAFEF00D);
`endif

      // Two wait states: write then read held on the bus until hready
      t_dut = 2'd1;
      put(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h00);
      tick();
      t_hwdata = 32'h5A5A0001;
      put(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h00);
      neg();
      chk_rsp("ws2_wr_w1", 1'b0, 1'b0);
      tick();
      neg();
      chk_rsp("ws2_wr_w2", 1'b0, 1'b0);
      tick();
      neg();
      chk_rsp("ws2_wr_data", 1'b1, 1'b0);
      tick();
      idle();
      neg();
      chk_rsp("ws2_rd_w1", 1'b0, 1'b0);
      chk("ws2_rd_w1.hrdata", m_rdata, 32'h0);
      tick();
      neg();
      chk_rsp("ws2_rd_w2", 1'b0, 1'b0);
      tick();
      neg();
      chk_rsp("ws2_rd_data", 1'b1, 1'b0);
      chk("ws2_rd_data.hrdata", m_rdata, 32'h5A5A0001);
      tick();
      neg();
      chk("ws2_after.hrdata", m_rdata, 32'h0);

      // Three wait states: seed 0x10, then reset in the middle of a write
      t_dut = 2'd2;
      put(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h10);
      tick();
      t_hwdata = 32'h01010101;
      idle();
      tick();
      tick();
      tick();
      neg();
      chk_rsp("ws3_seed_data", 1'b1, 1'b0);
      tick();

      put(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h10);
      tick();
      t_hwdata = 32'hFFFFFFFF;
      idle();
      neg();
      chk_rsp("ws3_pre_rst", 1'b0, 1'b0);
      tick();
      #2 rst_n = 1'b0;
      #1;
      chk_rsp("rst_mid", 1'b1, 1'b0);
      chk("rst_mid.hrdata", m_rdata, 32'h0);
      tick();
      tick();
      rst_n = 1'b1;
      put(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10);
      tick();
      idle();
      neg();
      chk_rsp("ws3_rd_w1", 1'b0, 1'b0);
      tick();
      neg();
      chk_rsp("ws3_rd_w2", 1'b0, 1'b0);
      tick();
      neg();
      chk_rsp("ws3_rd_w3", 1'b0, 1'b0);
      tick();
      neg();
      chk_rsp("ws3_rd_data", 1'b1, 1'b0);
      chk("ws3_rd_data.hrdata", m_rdata, 32'h01010101);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
